// File: rtl/adder_arb_pkg.sv
// Shared constants for the adder-sharing arbiter.
//   WIDTH   : operand/result width
//   NUM_REQ : number of requesters sharing the adder
//   ID_W    : requester id width
//   OP_ADD / OP_SUB : encoding of the per-requester req_sub bit
package adder_arb_pkg;
  localparam int   WIDTH   = 32;
  localparam int   NUM_REQ = 4;
  localparam int   ID_W    = $clog2(NUM_REQ);
  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_SUB  = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker.
//   req       : per-requester request vector
//   ptr       : index with highest priority this cycle
//   en        : when low, no grant is issued
//   grant     : one-hot grant (all zero if nothing granted)
//   grant_idx : binary index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int NUM_REQ = adder_arb_pkg::NUM_REQ,
  parameter int ID_W    = adder_arb_pkg::ID_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic found;
  int   idx;

  // Walk ptr, ptr+1, ... (mod NUM_REQ) and take the first active request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// One registered add/sub datapath shared by NUM_REQ requesters.
// A round-robin arbiter selects one request per cycle whenever the result
// register can accept; the chosen operands pass through a plain adder and the
// result plus requester id is registered onto a valid/ready output channel.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_sub    : per-requester strobe and op (0 add, 1 sub)
//   req_a/req_b          : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready            : one-hot accept
//   res_valid/res_ready  : output handshake
//   res_data/res_id      : result and producing requester
//   res_carry/res_ovf    : carry (sub: 1 = no borrow) and signed overflow
module adder_share_arbiter #(
  parameter int WIDTH   = adder_arb_pkg::WIDTH,
  parameter int NUM_REQ = adder_arb_pkg::NUM_REQ,
  parameter int ID_W    = adder_arb_pkg::ID_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [ID_W-1:0]          res_id,
  output logic                     res_carry,
  output logic                     res_ovf
);
  import adder_arb_pkg::*;

  logic             res_valid_reg;
  logic [WIDTH-1:0] res_data_reg;
  logic [ID_W-1:0]  res_id_reg;
  logic             res_carry_reg;
  logic             res_ovf_reg;
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [ID_W-1:0]  rr_ptr_next;

  logic                accept;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                granted;

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_eff;
  logic             sub_sel;
  logic [WIDTH:0]   sum_full;
  logic             ovf_next;

  // Result register may take a new value if empty or being drained now.
  assign accept = !res_valid_reg || res_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .en        (accept && !rst),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign granted   = |grant;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Subtraction is A + ~B + 1 so carry-out directly means "no borrow".
  assign a_sel    = a_arr[grant_idx];
  assign sub_sel  = req_sub[grant_idx];
  assign b_eff    = (sub_sel == OP_SUB) ? ~b_arr[grant_idx] : b_arr[grant_idx];
  assign sum_full = {1'b0, a_sel} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
  assign ovf_next = (a_sel[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum_full[WIDTH-1] != a_sel[WIDTH-1]);

  assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_id_reg    <= '0;
      res_carry_reg <= 1'b0;
      res_ovf_reg   <= 1'b0;
      rr_ptr_reg    <= '0;
    end else if (granted) begin
      res_valid_reg <= 1'b1;
      res_data_reg  <= sum_full[WIDTH-1:0];
      res_id_reg    <= grant_idx;
      res_carry_reg <= sum_full[WIDTH];
      res_ovf_reg   <= ovf_next;
      rr_ptr_reg    <= rr_ptr_next;
    end else if (res_ready) begin
      // Drain only: data fields keep their last value.
      res_valid_reg <= 1'b0;
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;
  assign res_carry = res_carry_reg;
  assign res_ovf   = res_ovf_reg;

endmodule
